// File: rtl/decode_queue.sv
// Decode queue: DEPTH-entry {instr, pc} FIFO between fetch and execute, with combinational
// RV32I decode of the head entry. Define DECODE_RV32M_EN to decode M-extension ops instead of flagging them illegal.
package rv32i_types;
    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;
    localparam logic [6:0] op_csr   = 7'b1110011;

    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        br_beq = 3'b000, br_bne = 3'b001, br_blt = 3'b100,
        br_bge = 3'b101, br_bltu = 3'b110, br_bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic {alumux1_rs1_out, alumux1_pc_out} alumux1_sel_t;
    typedef enum logic [2:0] {
        alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2_out
    } alumux2_sel_t;
    typedef enum logic {cmpmux_rs2_out, cmpmux_i_imm} cmpmux_sel_t;
    typedef enum logic [1:0] {pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2} pcmux_sel_t;
    typedef enum logic [3:0] {
        rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
    } regfilemux_sel_t;

    typedef struct packed {
        logic [6:0]      opcode;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        pcmux_sel_t      pcmux_sel;
        regfilemux_sel_t regfilemux_sel;
        regfilemux_sel_t mem_rdatamux_sel;
        logic            regwrite_en;
        logic            mem_read;
        logic            mem_write;
        logic [3:0]      mem_byte_enable;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } rv32i_control_word;
endpackage

module decode_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output rv32i_control_word          out_ctrl,
    output logic                       out_illegal,
    output logic                       out_is_muldiv,
    output logic [2:0]                 out_muldiv_op,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic            push, pop;

    assign in_ready  = rst_n && !flush && (count_q < CW'(DEPTH));
    assign out_valid = rst_n && (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Flush realigns the read pointer onto the write pointer and drops any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    logic [XLEN-1:0] head_instr;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic            dec_wr, dec_ill, dec_md;
    rv32i_control_word ctrl;

    assign head_instr = instr_mem[rd_ptr];
    assign out_instr  = head_instr;
    assign out_pc     = pc_mem[rd_ptr];
    assign opcode     = head_instr[6:0];
    assign rd         = head_instr[11:7];
    assign funct3     = head_instr[14:12];
    assign rs1        = head_instr[19:15];
    assign rs2        = head_instr[24:20];
    assign funct7     = head_instr[31:25];

    always_comb begin
        ctrl        = '0;
        ctrl.opcode = opcode;
        dec_wr      = 1'b0;
        dec_ill     = 1'b0;
        dec_md      = 1'b0;
        case (opcode)
            op_lui: begin
                dec_wr                = 1'b1;
                ctrl.regfilemux_sel   = rf_u_imm;
                ctrl.mem_rdatamux_sel = rf_u_imm;
            end
            op_auipc: begin
                dec_wr           = 1'b1;
                ctrl.alumux1_sel = alumux1_pc_out;
                ctrl.alumux2_sel = alumux2_u_imm;
            end
            op_jal: begin
                dec_wr              = 1'b1;
                ctrl.alumux1_sel    = alumux1_pc_out;
                ctrl.alumux2_sel    = alumux2_j_imm;
                ctrl.pcmux_sel      = pcmux_alu_mod2;
                ctrl.regfilemux_sel = rf_pc_plus4;
            end
            op_jalr: begin
                dec_wr              = 1'b1;
                ctrl.rs1            = rs1;
                ctrl.pcmux_sel      = pcmux_alu_mod2;
                ctrl.regfilemux_sel = rf_pc_plus4;
            end
            op_br: begin
                ctrl.rs1         = rs1;
                ctrl.rs2         = rs2;
                ctrl.alumux1_sel = alumux1_pc_out;
                ctrl.alumux2_sel = alumux2_b_imm;
                ctrl.cmpop       = branch_funct3_t'(funct3);
                dec_ill          = (funct3[2:1] == 2'b01);
            end
            op_load: begin
                dec_wr        = 1'b1;
                ctrl.rs1      = rs1;
                ctrl.mem_read = 1'b1;
                case (funct3)
                    3'b000:  ctrl.regfilemux_sel = rf_lb;
                    3'b001:  ctrl.regfilemux_sel = rf_lh;
                    3'b010:  ctrl.regfilemux_sel = rf_lw;
                    3'b100:  ctrl.regfilemux_sel = rf_lbu;
                    3'b101:  ctrl.regfilemux_sel = rf_lhu;
                    default: dec_ill = 1'b1;
                endcase
                ctrl.mem_rdatamux_sel = ctrl.regfilemux_sel;
            end
            op_store: begin
                ctrl.rs1         = rs1;
                ctrl.rs2         = rs2;
                ctrl.mem_write   = 1'b1;
                ctrl.alumux2_sel = alumux2_s_imm;
                case (funct3)
                    3'b000:  ctrl.mem_byte_enable = 4'b0001;
                    3'b001:  ctrl.mem_byte_enable = 4'b0011;
                    3'b010:  ctrl.mem_byte_enable = 4'b1111;
                    default: dec_ill = 1'b1;
                endcase
            end
            op_imm: begin
                dec_wr   = 1'b1;
                ctrl.rs1 = rs1;
            end
            op_reg: begin
                dec_wr           = 1'b1;
                ctrl.rs1         = rs1;
                ctrl.rs2         = rs2;
                ctrl.alumux2_sel = alumux2_rs2_out;
                if (funct7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    dec_md = 1'b1;
`else
                    dec_ill = 1'b1;
`endif
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 != 3'b000 && funct3 != 3'b101) dec_ill = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    dec_ill = 1'b1;
                end
            end
            op_csr: ;
            default: dec_ill = 1'b1;
        endcase

        // Integer ALU selection shared by register-immediate and register-register forms.
        if ((opcode == op_imm || opcode == op_reg) && !dec_md) begin
            case (funct3)
                3'b010, 3'b011: begin
                    ctrl.regfilemux_sel = rf_br_en;
                    if (funct3[0]) ctrl.cmpop = br_bltu;
                    else           ctrl.cmpop = br_blt;
                    if (opcode == op_imm) ctrl.cmpmux_sel = cmpmux_i_imm;
                end
                3'b101: begin
                    if (funct7[5]) ctrl.aluop = alu_sra;
                    else           ctrl.aluop = alu_srl;
                end
                3'b000: begin
                    if (opcode == op_reg && funct7[5]) ctrl.aluop = alu_sub;
                    else                               ctrl.aluop = alu_add;
                end
                default: ctrl.aluop = alu_ops'(funct3);
            endcase
        end

        if (dec_ill) begin
            ctrl        = '0;
            ctrl.opcode = opcode;
        end
        ctrl.regwrite_en = dec_wr && !dec_ill && (rd != 5'd0);
        ctrl.rd          = ctrl.regwrite_en ? rd : 5'd0;
    end

    assign out_ctrl      = ctrl;
    assign out_illegal   = dec_ill;
    assign out_is_muldiv = dec_md;
    assign out_muldiv_op = dec_md ? funct3 : 3'b000;
endmodule
